rtc_reader: RTL and testbench

- Upstream feeder of the VGA display controller (ModuloVGA).
- Periodically reads the RTC chip's date, time and timer registers over the multiplexed address/data bus.
- Holds them as committed BCD bytes driving DIA_T…SEGUNDOT_T and ALARMA.
- Outputs update atomically once per complete read sequence, so the display never shows a torn time.

---
 rtl/rtc_pkg.sv | 65 ++++++
 rtl/rtc_reader_if.sv | 22 ++
 rtl/rtc_bus_cycle.sv | 94 +++++++++
 rtl/rtc_reader.sv | 164 ++++++++++++++++
 tb/tb_rtc_reader.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_pkg.sv
// RTC reader shared definitions: register map, transfer command, FSM encodings.
// Latency: n/a (constants, types and a pure lookup function only).
// Backpressure: n/a.
package rtc_pkg;

  // Transfer command written in the first address phase of every sequence.
  localparam logic [7:0] RTC_CMD_XFER = 8'hF0;

  // Date/time registers.
  localparam logic [7:0] RTC_ADDR_SEG  = 8'h21;
  localparam logic [7:0] RTC_ADDR_MIN  = 8'h22;
  localparam logic [7:0] RTC_ADDR_HORA = 8'h23;
  localparam logic [7:0] RTC_ADDR_DIA  = 8'h24;
  localparam logic [7:0] RTC_ADDR_MES  = 8'h25;
  localparam logic [7:0] RTC_ADDR_ANO  = 8'h26;

  // Timer registers.
  localparam logic [7:0] RTC_ADDR_SEGT  = 8'h41;
  localparam logic [7:0] RTC_ADDR_MINT  = 8'h42;
  localparam logic [7:0] RTC_ADDR_HORAT = 8'h43;

  // Index of the last register read in a sequence (nine reads, 0..8).
  localparam logic [3:0] RTC_LAST_IDX = 4'd8;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    CMD_ADDR,
    CMD_GAP,
    ADDR,
    ADDR_GAP,
    DATA,
    DATA_GAP,
    COMMIT
  } rtc_state_t;

  // Single-access engine states.
  typedef enum logic [2:0] {
    BC_IDLE,
    BC_ADDR,
    BC_AGAP,
    BC_DATA,
    BC_DGAP
  } bc_state_t;

  // Read order: idx -> RTC register address.
  function automatic logic [7:0] reg_addr(input logic [3:0] idx);
    logic [7:0] a;
    a = 8'h00;
    case (idx)
      4'd0:    a = RTC_ADDR_SEG;
      4'd1:    a = RTC_ADDR_MIN;
      4'd2:    a = RTC_ADDR_HORA;
      4'd3:    a = RTC_ADDR_DIA;
      4'd4:    a = RTC_ADDR_MES;
      4'd5:    a = RTC_ADDR_ANO;
      4'd6:    a = RTC_ADDR_SEGT;
      4'd7:    a = RTC_ADDR_MINT;
      4'd8:    a = RTC_ADDR_HORAT;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtc_reader_if.sv
// RTC multiplexed address/data bus: AD byte lanes plus active-low strobes.
// Latency: n/a (wires only). Backpressure: none, the bus is timed by the master.
// Ports: ad_in (RTC->master), ad_out/ad_oe, cs_n/rd_n/wr_n, a_d (master->RTC).
interface rtc_reader_if;
  logic [7:0] ad_in;   // read data from the RTC
  logic [7:0] ad_out;  // value driven onto AD when ad_oe=1
  logic       ad_oe;   // 1 = master drives AD
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d;     // 0 = address phase, 1 = data phase

  modport master (
    input  ad_in,
    output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
  );

  modport slave (
    output ad_in,
    input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
  );
endinterface

// File: rtl/rtc_bus_cycle.sv
// Single RTC access: address phase + gap, optionally data phase + gap.
// Latency: PHASE_CYC+GAP_CYC (write) or 2*(PHASE_CYC+GAP_CYC) (read) cycles.
// Backpressure: none; start is taken in BC_IDLE or on the done cycle for back-to-back.
// Ports: start/addr/read_en request, done pulse on the final gap cycle,
// phase_last on the last cycle of every phase/gap, rdata captured at end of data phase.
module rtc_bus_cycle
  import rtc_pkg::*;
#(
  parameter int PHASE_CYC = 10,
  parameter int GAP_CYC   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    addr,
  input  logic          read_en,
  output logic          done,
  output logic          phase_last,
  output logic [7:0]    rdata,
  rtc_reader_if.master  bus
);

  localparam int MAXC = (PHASE_CYC > GAP_CYC) ? PHASE_CYC : GAP_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  bc_state_t       state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            rd_q;
  logic            accept;

  always_comb begin
    phase_last = 1'b0;
    case (state)
      BC_ADDR, BC_DATA: phase_last = (cnt == CW'(PHASE_CYC - 1));
      BC_AGAP, BC_DGAP: phase_last = (cnt == CW'(GAP_CYC - 1));
      default:          phase_last = 1'b0;
    endcase
  end

  // A write access ends after its address gap, a read after its data gap.
  assign done   = phase_last && ((state == BC_AGAP && !rd_q) || state == BC_DGAP);
  assign accept = start && (state == BC_IDLE || done);

  always_comb begin
    state_nxt = state;
    case (state)
      BC_IDLE: if (start)      state_nxt = BC_ADDR;
      BC_ADDR: if (phase_last) state_nxt = BC_AGAP;
      BC_AGAP: if (phase_last) state_nxt = rd_q ? BC_DATA : (start ? BC_ADDR : BC_IDLE);
      BC_DATA: if (phase_last) state_nxt = BC_DGAP;
      BC_DGAP: if (phase_last) state_nxt = start ? BC_ADDR : BC_IDLE;
      default:                 state_nxt = BC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BC_IDLE;
      cnt   <= '0;
      rd_q  <= 1'b0;
      rdata <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)    cnt <= '0;
      else if (state != BC_IDLE) cnt <= cnt + CW'(1);
      if (accept) rd_q <= read_en;
      if (state == BC_DATA && phase_last) rdata <= bus.ad_in;
    end
  end

  // Strobes are registered from the next state so the pins never glitch
  // on multi-bit state decode and still change on the same edge as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.cs_n   <= 1'b1;
      bus.rd_n   <= 1'b1;
      bus.wr_n   <= 1'b1;
      bus.a_d    <= 1'b0;
      bus.ad_oe  <= 1'b0;
      bus.ad_out <= 8'h00;
    end else begin
      bus.cs_n  <= !(state_nxt == BC_ADDR || state_nxt == BC_DATA);
      bus.wr_n  <= !(state_nxt == BC_ADDR);
      bus.rd_n  <= !(state_nxt == BC_DATA);
      bus.ad_oe <= (state_nxt == BC_ADDR);
      // a_d only moves on entry to a phase; gaps keep the last value.
      if (state_nxt == BC_ADDR)      bus.a_d <= 1'b0;
      else if (state_nxt == BC_DATA) bus.a_d <= 1'b1;
      if (accept)                    bus.ad_out <= addr;
      else if (state_nxt != BC_ADDR) bus.ad_out <= 8'h00;
    end
  end

endmodule

// File: rtl/rtc_reader.sv
// Periodically reads RTC date/time/timer and commits all nine BCD bytes at once.
// Latency: (PHASE_CYC+GAP_CYC)*19+1 cycles from sequence start to committed outputs.
// Backpressure: bus_busy holds off new sequences (sampled in IDLE only); pending is kept.
// Ports: clk/rst, bus_busy, alarm_ack, RTC bus (master), segundo..horat, alarma, valid, busy.
module rtc_reader
  import rtc_pkg::*;
#(
  parameter int REFRESH_CYC = 1000000,
  parameter int PHASE_CYC   = 10,
  parameter int GAP_CYC     = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bus_busy,
  input  logic          alarm_ack,
  rtc_reader_if.master  bus,
  output logic [7:0]    segundo,
  output logic [7:0]    minuto,
  output logic [7:0]    hora,
  output logic [7:0]    dia,
  output logic [7:0]    mes,
  output logic [7:0]    ano,
  output logic [7:0]    segundot,
  output logic [7:0]    minutot,
  output logic [7:0]    horat,
  output logic          alarma,
  output logic          valid,
  output logic          busy
);

  localparam int RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

  rtc_state_t       state, state_nxt;
  logic [RW-1:0]    rcnt;
  logic             wrap;
  logic             pending;
  logic             start_seq;
  logic [3:0]       idx;

  logic             eng_start;
  logic             eng_read;
  logic [7:0]       eng_addr;
  logic             eng_done;
  logic             eng_last;
  logic [7:0]       eng_rdata;

  // Entry order follows idx: [0]=segundo .. [5]=ano, [6]=segundot .. [8]=horat.
  logic [8:0][7:0]  shadow;
  logic [8:0][7:0]  cur;
  logic             alarm_set;

  rtc_bus_cycle #(
    .PHASE_CYC (PHASE_CYC),
    .GAP_CYC   (GAP_CYC)
  ) u_bus_cycle (
    .clk        (clk),
    .rst        (rst),
    .start      (eng_start),
    .addr       (eng_addr),
    .read_en    (eng_read),
    .done       (eng_done),
    .phase_last (eng_last),
    .rdata      (eng_rdata),
    .bus        (bus)
  );

  assign wrap      = (rcnt == RW'(REFRESH_CYC - 1));
  assign start_seq = (state == IDLE) && pending && !bus_busy;

  // Sequencer; each engine start is issued on the cycle the previous access
  // completes so the next address phase follows its gap with no bubble.
  always_comb begin
    state_nxt = state;
    eng_start = 1'b0;
    eng_read  = 1'b0;
    eng_addr  = 8'h00;
    case (state)
      IDLE: begin
        if (start_seq) begin
          state_nxt = CMD_ADDR;
          eng_start = 1'b1;
          eng_addr  = RTC_CMD_XFER;
        end
      end
      CMD_ADDR: if (eng_last) state_nxt = CMD_GAP;
      CMD_GAP: begin
        if (eng_done) begin
          state_nxt = ADDR;
          eng_start = 1'b1;
          eng_read  = 1'b1;
          eng_addr  = reg_addr(4'd0);
        end
      end
      ADDR:     if (eng_last) state_nxt = ADDR_GAP;
      ADDR_GAP: if (eng_last) state_nxt = DATA;
      DATA:     if (eng_last) state_nxt = DATA_GAP;
      DATA_GAP: begin
        if (eng_done) begin
          if (idx == RTC_LAST_IDX) begin
            state_nxt = COMMIT;
          end else begin
            state_nxt = ADDR;
            eng_start = 1'b1;
            eng_read  = 1'b1;
            eng_addr  = reg_addr(idx + 4'd1);
          end
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Alarm fires only on the transition of a committed timer to 00:00:00.
  assign alarm_set = (state == COMMIT) && valid &&
                     (cur[8:6] != '0) && (shadow[8:6] == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rcnt    <= '0;
      pending <= 1'b1;
      idx     <= 4'd0;
      shadow  <= '0;
      cur     <= '0;
      valid   <= 1'b0;
      alarma  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      rcnt  <= wrap ? '0 : rcnt + RW'(1);
      // A wrap while a sequence runs stays latched and triggers the next one.
      pending <= start_seq ? 1'b0 : (pending | wrap);

      if (state == CMD_GAP && eng_done)
        idx <= 4'd0;
      else if (state == DATA_GAP && eng_done && idx != RTC_LAST_IDX)
        idx <= idx + 4'd1;

      if (state == DATA_GAP && eng_done)
        shadow[idx] <= eng_rdata;

      if (state == COMMIT) begin
        cur   <= shadow;
        valid <= 1'b1;
      end

      if (alarm_set)      alarma <= 1'b1;
      else if (alarm_ack) alarma <= 1'b0;
    end
  end

  assign segundo  = cur[0];
  assign minuto   = cur[1];
  assign hora     = cur[2];
  assign dia      = cur[3];
  assign mes      = cur[4];
  assign ano      = cur[5];
  assign segundot = cur[6];
  assign minutot  = cur[7];
  assign horat    = cur[8];

endmodule

// File: tb/tb_rtc_reader.sv
// Bench for rtc_reader: RTC register model on the AD bus, table of commits,
// plus directed sequences for atomicity, arbitration and mid-sequence reset.
module tb_rtc_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bus_busy = 1'b0;
  logic       alarm_ack = 1'b0;
  logic [7:0] segundo, minuto, hora, dia, mes, ano, segundot, minutot, horat;
  logic       alarma, valid, busy;

  rtc_reader_if bus ();

  rtc_reader #(
    .REFRESH_CYC (600),
    .PHASE_CYC   (10),
    .GAP_CYC     (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_busy  (bus_busy),
    .alarm_ack (alarm_ack),
    .bus       (bus),
    .segundo   (segundo),
    .minuto    (minuto),
    .hora      (hora),
    .dia       (dia),
    .mes       (mes),
    .ano       (ano),
    .segundot  (segundot),
    .minutot   (minutot),
    .horat     (horat),
    .alarma    (alarma),
    .valid     (valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // RTC model: latch the address written in an address phase, return its byte.
  logic [7:0] rtc_mem [256];
  logic [7:0] lat_addr = 8'h00;
  always @(posedge clk)
    if (!bus.cs_n && !bus.wr_n && !bus.a_d) lat_addr <= bus.ad_out;
  assign bus.ad_in = rtc_mem[lat_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] sec, mnu, hr, dy, mo, yr, ts, tm, th;
    logic       ack_before;
    logic       ack_commit;
    logic       exp_alarma;
  } vec_t;

  task automatic load_model(input vec_t v);
    rtc_mem[8'h21] = v.sec; rtc_mem[8'h22] = v.mnu; rtc_mem[8'h23] = v.hr;
    rtc_mem[8'h24] = v.dy;  rtc_mem[8'h25] = v.mo;  rtc_mem[8'h26] = v.yr;
    rtc_mem[8'h41] = v.ts;  rtc_mem[8'h42] = v.tm;  rtc_mem[8'h43] = v.th;
  endtask

  task automatic chk_outputs(input string tag, input vec_t v);
    chk({tag, ".segundo"},  segundo,  v.sec);
    chk({tag, ".minuto"},   minuto,   v.mnu);
    chk({tag, ".hora"},     hora,     v.hr);
    chk({tag, ".dia"},      dia,      v.dy);
    chk({tag, ".mes"},      mes,      v.mo);
    chk({tag, ".ano"},      ano,      v.yr);
    chk({tag, ".segundot"}, segundot, v.ts);
    chk({tag, ".minutot"},  minutot,  v.tm);
    chk({tag, ".horat"},    horat,    v.th);
  endtask

  // Wait (bounded) for a fresh sequence and its commit; optionally pulse
  // alarm_ack during the COMMIT cycle (cycle 285 after the start edge).
  task automatic run_seq(input logic ack_commit);
    int n;
    n = 0;
    while (!busy && n < 1500) begin @(negedge clk); n++; end
    chk("seq_start", busy, 1'b1);
    if (!busy) return;
    if (ack_commit) begin
      repeat (285) @(negedge clk);
      alarm_ack = 1'b1;
      @(negedge clk);
      alarm_ack = 1'b0;
    end
    n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    chk("seq_end", busy, 1'b0);
  endtask

  vec_t tbl [7];

  initial begin
    vec_t v;
    int   n, cnt, torn;

    for (int i = 0; i < 256; i++) rtc_mem[i] = 8'h00;

    //          sec    mnu    hr     dy     mo     yr     ts     tm     th   ackb  ackc  alarma
    tbl[0] = '{8'h00, 8'h00, 8'h50, 8'h10, 8'h04, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h00, 8'h50, 8'h10, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{8'h01, 8'h00, 8'h50, 8'h10, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 8'hAB, 8'h23, 8'h31, 8'h12, 8'h99, 8'h56, 8'h34, 8'h12, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'h07, 8'h08, 8'h09, 8'h02, 8'h03, 8'h24, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};

    // ---- reset: 100 ns low, no strobe activity, everything zero ----
    v = '{8'h00, 8'h00, 8'h50, 8'h10, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    load_model(v);
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (!bus.cs_n || !bus.rd_n || !bus.wr_n) cnt++;
    end
    chk("rst_strobes", cnt, 0);
    chk("rst_cs_n", bus.cs_n, 1'b1);
    chk("rst_ad_oe", bus.ad_oe, 1'b0);
    chk("rst_ad_out", bus.ad_out, 8'h00);
    chk("rst_a_d", bus.a_d, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_alarma", alarma, 1'b0);
    chk("rst_dia", dia, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // ---- first sequence: cs_n low one edge after release, 0xF0 for 10 cycles ----
    @(negedge clk);
    chk("first_cs_n", bus.cs_n, 1'b0);
    chk("first_wr_n", bus.wr_n, 1'b0);
    chk("first_ad_out", bus.ad_out, 8'hF0);
    chk("first_ad_oe", bus.ad_oe, 1'b1);
    chk("first_busy", busy, 1'b1);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (!bus.cs_n && bus.ad_out == 8'hF0) cnt++;
      @(negedge clk);
    end
    chk("cmd_cycles", cnt, 10);
    repeat (270) @(negedge clk);
    chk("pre_commit_valid", valid, 1'b0);
    chk("pre_commit_busy", busy, 1'b1);
    @(negedge clk);
    chk("commit_valid", valid, 1'b1);
    chk("commit_busy", busy, 1'b0);
    chk_outputs("first", v);

    // ---- table of successive commits (alarm behaviour, passthrough) ----
    for (int r = 0; r < 7; r++) begin
      if (tbl[r].ack_before) begin
        alarm_ack = 1'b1;
        @(negedge clk);
        alarm_ack = 1'b0;
        chk($sformatf("row%0d.ack_clears", r), alarma, 1'b0);
      end
      load_model(tbl[r]);
      run_seq(tbl[r].ack_commit);
      chk_outputs($sformatf("row%0d", r), tbl[r]);
      chk($sformatf("row%0d.alarma", r), alarma, tbl[r].exp_alarma);
      chk($sformatf("row%0d.valid", r), valid, 1'b1);
    end

    // ---- atomicity: segundo changes during the hora read ----
    v = '{8'h59, 8'h30, 8'h50, 8'h10, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    load_model(v);
    run_seq(1'b0);
    chk_outputs("atom_base", v);
    rtc_mem[8'h23] = 8'h51;
    rtc_mem[8'h22] = 8'h07;
    n = 0;
    while (!busy && n < 1500) begin @(negedge clk); n++; end
    chk("atom_start", busy, 1'b1);
    torn = 0;
    n = 0;
    while (busy && n < 400) begin
      if (segundo != 8'h59 || minuto != 8'h30 || hora != 8'h50) torn++;
      if (lat_addr == 8'h23 && !bus.rd_n) rtc_mem[8'h21] = 8'h00;
      @(negedge clk);
      n++;
    end
    chk("atom_no_tear", torn, 0);
    chk("atom_end", busy, 1'b0);
    chk("atom_segundo_old", segundo, 8'h59);
    chk("atom_minuto_new", minuto, 8'h07);
    chk("atom_hora_new", hora, 8'h51);
    run_seq(1'b0);
    chk("atom_segundo_next", segundo, 8'h00);

    // ---- arbitration: bus_busy across a refresh wrap ----
    bus_busy = 1'b1;
    cnt = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (!bus.cs_n || busy) cnt++;
    end
    chk("arb_held_off", cnt, 0);
    bus_busy = 1'b0;
    @(negedge clk);
    chk("arb_start_busy", busy, 1'b1);
    chk("arb_start_cs_n", bus.cs_n, 1'b0);
    chk("arb_start_cmd", bus.ad_out, 8'hF0);
    repeat (40) @(negedge clk);
    bus_busy = 1'b1;
    n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    chk("arb_mid_completes", busy, 1'b0);
    chk("arb_mid_hora", hora, 8'h51);
    bus_busy = 1'b0;

    // ---- reset during the 5th data phase (mes) ----
    n = 0;
    while (!busy && n < 1500) begin @(negedge clk); n++; end
    chk("mid_rst_start", busy, 1'b1);
    n = 0;
    while (!(lat_addr == 8'h25 && !bus.rd_n && !bus.cs_n) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rst_in_data", bus.rd_n, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_cs_n", bus.cs_n, 1'b1);
    chk("mid_rst_rd_n", bus.rd_n, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_alarma", alarma, 1'b0);
    chk("mid_rst_hora", hora, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("restart_cs_n", bus.cs_n, 1'b0);
    chk("restart_cmd", bus.ad_out, 8'hF0);
    n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    chk("restart_end", busy, 1'b0);
    chk("restart_valid", valid, 1'b1);
    chk("restart_mes", mes, 8'h04);
    chk("restart_hora", hora, 8'h51);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
